// File: rtl/conway_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : conway_mode_controller
//  Description : Sequences the Game-of-Life grid memory through serial load,
//                multi-generation run and serial readout. All outputs are
//                registered; one mode strobe at a time drives the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module conway_mode_controller #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_load,
  input  logic                 start_run,
  input  logic [GEN_WIDTH-1:0] gen_count,
  input  logic                 start_output,
  input  logic                 abort,
  output logic                 load_mode,
  output logic                 run_mode,
  output logic                 output_mode,
  output logic                 serial_valid,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_WIDTH-1:0] gen_remaining
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);
  // Bit index of the final shifted bit, and the extra trailing readout cycle
  // during which serial_valid is still high but output_mode has dropped.
  localparam logic [CNT_W-1:0]     C_LAST_BIT = CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0]     C_TRAIL    = CNT_W'(DATA_SIZE);
  localparam logic [CNT_W-1:0]     C_CNT_ONE  = CNT_W'(1);
  localparam logic [GEN_WIDTH-1:0] C_GEN_ONE  = GEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GEN_WIDTH-1:0] gen_rem_q, gen_rem_d;
  logic                 load_q, load_d;
  logic                 run_q, run_d;
  logic                 out_q, out_d;
  logic                 sv_q, sv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gen_rem_d = gen_rem_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort in IDLE swallows any simultaneous start.
        if (!abort) begin
          if (start_run) begin
            gen_rem_d = gen_count;
            if (gen_count == '0) begin
              done_d = 1'b1;          // nothing to run: complete immediately
            end else begin
              state_d = RUN;
            end
          end else if (start_load) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
          end else if (start_output) begin
            state_d   = OUTPUT;
            bit_cnt_d = '0;
          end
        end
      end
      LOAD: begin
        bit_cnt_d = bit_cnt_q + C_CNT_ONE;
        if (bit_cnt_q == C_LAST_BIT) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          done_d    = 1'b1;
        end
      end
      RUN: begin
        gen_rem_d = gen_rem_q - C_GEN_ONE;
        if (gen_rem_q == C_GEN_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      OUTPUT: begin
        // Counts DATA_SIZE shift cycles plus one trailing valid cycle.
        bit_cnt_d = bit_cnt_q + C_CNT_ONE;
        if (bit_cnt_q == C_TRAIL) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      gen_rem_d = '0;
      done_d    = 1'b0;
    end

    load_d = (state_d == LOAD);
    run_d  = (state_d == RUN);
    out_d  = (state_d == OUTPUT) && (bit_cnt_d != C_TRAIL);
    // Memory serial_out is registered, so valid data lags output_mode by one.
    sv_d   = out_q && (state_d == OUTPUT);
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gen_rem_q <= '0;
      load_q    <= 1'b0;
      run_q     <= 1'b0;
      out_q     <= 1'b0;
      sv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gen_rem_q <= gen_rem_d;
      load_q    <= load_d;
      run_q     <= run_d;
      out_q     <= out_d;
      sv_q      <= sv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign load_mode     = load_q;
  assign run_mode      = run_q;
  assign output_mode   = out_q;
  assign serial_valid  = sv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign gen_remaining = gen_rem_q;

endmodule
`default_nettype wire

// File: tb/tb_conway_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conway_mode_controller
//  Description : Self-checking bench for conway_mode_controller: a timeline
//                reference model checked every cycle, directed scenarios with
//                literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conway_mode_controller;

  localparam int DS = 64;
  localparam int GW = 8;
  localparam int VW = GW + 6;
  // Field positions within the packed output vector.
  localparam int B_LD = GW + 5;
  localparam int B_RN = GW + 4;
  localparam int B_OM = GW + 3;
  localparam int B_SV = GW + 2;
  localparam int B_BZ = GW + 1;
  localparam int B_DN = GW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_load = 1'b0;
  logic          start_run = 1'b0;
  logic          start_output = 1'b0;
  logic          abort = 1'b0;
  logic [GW-1:0] gen_count = '0;
  logic          load_mode, run_mode, output_mode, serial_valid, busy, done;
  logic [GW-1:0] gen_remaining;

  always #5 clk = ~clk;

  conway_mode_controller #(.DATA_SIZE(DS), .GEN_WIDTH(GW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_load   (start_load),
    .start_run    (start_run),
    .gen_count    (gen_count),
    .start_output (start_output),
    .abort        (abort),
    .load_mode    (load_mode),
    .run_mode     (run_mode),
    .output_mode  (output_mode),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done),
    .gen_remaining(gen_remaining)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {load_mode, run_mode, output_mode, serial_valid, busy, done, gen_remaining};
  endfunction

  // ---------------- reference model: one operation timeline ----------------
  // m_op: 0 none, 1 load, 2 run, 3 output. m_a is the accepting edge number;
  // d = 1 denotes the first cycle after that edge.
  int e_cnt = 0;
  int m_a   = 0;
  int m_op  = 0;
  int m_g   = 0;

  function automatic int busy_end();
    if (m_op == 3) return DS + 1;
    if (m_op == 2) return m_g;
    return DS;
  endfunction

  function automatic logic [VW-1:0] expect_vec(input int d);
    logic ld, rn, om, sv, bz, dn;
    logic [GW-1:0] gr;
    int b;
    b  = busy_end();
    ld = (m_op == 1) && d >= 1 && d <= DS;
    rn = (m_op == 2) && d >= 1 && d <= m_g;
    om = (m_op == 3) && d >= 1 && d <= DS;
    sv = (m_op == 3) && d >= 2 && d <= DS + 1;
    bz = (m_op != 0) && d >= 1 && d <= b;
    dn = (m_op != 0) && d == b + 1;
    gr = rn ? GW'(m_g - d + 1) : '0;
    return {ld, rn, om, sv, bz, dn, gr};
  endfunction

  always @(posedge clk) begin
    int dp;
    logic prev_busy;
    dp = e_cnt - m_a + 1;
    prev_busy = (m_op != 0) && dp >= 1 && dp <= busy_end();
    e_cnt++;
    if (reset) begin
      m_op = 0;
    end else if (prev_busy) begin
      if (abort) m_op = 0;
    end else if (!abort) begin
      if (start_run) begin
        m_op = 2; m_g = int'(gen_count); m_a = e_cnt;
      end else if (start_load) begin
        m_op = 1; m_a = e_cnt;
      end else if (start_output) begin
        m_op = 3; m_a = e_cnt;
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_model", 64'(dut_vec()), 64'(expect_vec(e_cnt - m_a + 1)));
      check("mode_onehot", 64'($countones({load_mode, run_mode, output_mode}) <= 1), 64'd1);
    end
  end

  // ---------------- grid memory stand-in for the serial stream ----------------
  logic [DS-1:0] mem_q = {8{8'hA5}};
  logic          ser_out = 1'b0;
  logic [DS-1:0] cap = '0;

  always @(posedge clk) begin
    if (output_mode) begin
      ser_out <= mem_q[DS-1];
      mem_q   <= {mem_q[DS-2:0], mem_q[DS-1]};
    end
  end

  always @(negedge clk) begin
    if (serial_valid) cap = {cap[DS-2:0], ser_out};
  end

  // ---------------- directed operation helper ----------------
  logic [VW-1:0] lg [0:299];

  // Called at a negedge: applies starts now, then logs n cycles (k = 1 is the
  // cycle after the accepting edge). rk/ak/rst_k inject start_load, abort or
  // reset during cycle k (0 = together with the start, -1 = never).
  task automatic op(input logic sr, input logic sl, input logic so, input logic [GW-1:0] g,
                    input int n, input int rk, input int ak, input int rst_k);
    start_run = sr; start_load = sl; start_output = so; gen_count = g;
    abort = (ak == 0); reset = (rst_k == 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      lg[k] = dut_vec();
      start_run = 1'b0; start_output = 1'b0;
      start_load = (k == rk);
      abort      = (k == ak);
      reset      = (k == rst_k);
    end
  endtask

  function automatic int cnt(input int b, input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (lg[k][b]) c++;
    return c;
  endfunction

  function automatic int first(input int b, input int n);
    for (int k = 1; k <= n; k++) if (lg[k][b]) return k;
    return 0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] gr_seq;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(dut_vec()), 64'd0);
    chk_en = 1'b1;

    // Load accepted on the first edge with reset low.
    op(1'b0, 1'b1, 1'b0, '0, 70, -1, -1, -1);
    check("load_cycles", cnt(B_LD, 70), 64);
    check("load_first", first(B_LD, 70), 1);
    check("load_done_at", first(B_DN, 70), 65);
    check("load_done_cnt", cnt(B_DN, 70), 1);
    check("load_busy_cnt", cnt(B_BZ, 70), 64);

    // Run of 5 generations: remaining count 5,4,3,2,1 then 0.
    op(1'b1, 1'b0, 1'b0, 8'd5, 10, -1, -1, -1);
    gr_seq = '0;
    for (int k = 1; k <= 6; k++) gr_seq = {gr_seq[39:0], lg[k][GW-1:0]};
    check("run5_cycles", cnt(B_RN, 10), 5);
    check("run5_remaining", gr_seq, 48'h050403020100);
    check("run5_done_at", first(B_DN, 10), 6);
    check("run5_done_cnt", cnt(B_DN, 10), 1);

    // Zero generations: no run, done straight away.
    op(1'b1, 1'b0, 1'b0, 8'd0, 4, -1, -1, -1);
    check("run0_cycles", cnt(B_RN, 4), 0);
    check("run0_done_at", first(B_DN, 4), 1);
    check("run0_busy", cnt(B_BZ, 4), 0);

    // Full-scale count must not wrap.
    op(1'b1, 1'b0, 1'b0, 8'hFF, 260, -1, -1, -1);
    check("run255_cycles", cnt(B_RN, 260), 255);
    check("run255_first_rem", lg[1][GW-1:0], 8'hFF);
    check("run255_done_at", first(B_DN, 260), 256);

    // Readout of a preloaded A5 pattern.
    cap = '0;
    op(1'b0, 1'b0, 1'b1, '0, 70, -1, -1, -1);
    check("out_mode_cycles", cnt(B_OM, 70), 64);
    check("out_sv_first", first(B_SV, 70), 2);
    check("out_sv_cycles", cnt(B_SV, 70), 64);
    check("out_busy_cycles", cnt(B_BZ, 70), 65);
    check("out_done_at", first(B_DN, 70), 66);
    check("out_stream", cap, 64'hA5A5A5A5A5A5A5A5);

    // All three starts together: only the run executes.
    op(1'b1, 1'b1, 1'b1, 8'd3, 10, -1, -1, -1);
    check("prio_run_cycles", cnt(B_RN, 10), 3);
    check("prio_other_modes", cnt(B_LD, 10) + cnt(B_OM, 10), 0);

    // start_load repeated mid-LOAD is ignored.
    op(1'b0, 1'b1, 1'b0, '0, 80, 10, -1, -1);
    check("reload_ignored_cycles", cnt(B_LD, 80), 64);
    check("reload_done_cnt", cnt(B_DN, 80), 1);

    // Abort during the 30th load cycle.
    op(1'b0, 1'b1, 1'b0, '0, 40, -1, 30, -1);
    check("abort_load_cycles", cnt(B_LD, 40), 30);
    check("abort_next_zero", 64'(lg[31]), 64'd0);
    check("abort_no_done", cnt(B_DN, 40), 0);
    op(1'b0, 1'b1, 1'b0, '0, 70, -1, -1, -1);
    check("after_abort_load", cnt(B_LD, 70), 64);

    // Reset mid-OUTPUT.
    op(1'b0, 1'b0, 1'b1, '0, 40, -1, -1, 20);
    check("rst_out_cycles", cnt(B_OM, 40), 20);
    check("rst_out_next_zero", 64'(lg[21]), 64'd0);
    check("rst_out_no_done", cnt(B_DN, 40), 0);
    op(1'b0, 1'b1, 1'b0, '0, 3, -1, -1, -1);
    check("after_rst_load", lg[1][B_LD], 1'b1);

    // Abort together with a start in IDLE drops the start.
    op(1'b0, 1'b1, 1'b0, '0, 70, -1, 0, -1);
    check("idle_abort_drops", cnt(B_BZ, 3), 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 6000; i++) begin
      start_run    = ($urandom_range(0, 99) < 3);
      start_load   = ($urandom_range(0, 99) < 3);
      start_output = ($urandom_range(0, 99) < 3);
      abort        = ($urandom_range(0, 999) < 8);
      reset        = ($urandom_range(0, 999) < 3);
      gen_count    = ($urandom_range(0, 9) == 0) ? 8'hFF : GW'($urandom_range(0, 12));
      @(negedge clk);
    end
    start_run = 1'b0; start_load = 1'b0; start_output = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (300) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
